// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit barrier arbiter for a parking lot: grants the single gate to one
// lane at a time, tracks occupancy and abandons a grant that sees no car within TIMEOUT cycles.
module parking_gate_arbiter #(
  parameter int MAX_SPACES = 100,
  parameter int TIMEOUT    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Enter_Req,
  input  logic       Exit_Req,
  input  logic       Car_Passed,
  output logic       Enter_Grant,
  output logic       Exit_Grant,
  output logic       Gate_Open,
  output logic [6:0] Count,
  output logic       Full,
  output logic       Timeout_Err
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_ENTER = 2'd1,
    GRANT_EXIT  = 2'd2,
    CLOSE       = 2'd3
  } state_t;

  localparam logic [6:0] MAX_CNT    = 7'(MAX_SPACES);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [6:0] count_reg, count_next;
  logic [7:0] timer_reg, timer_next;
  logic       last_exit_reg, last_exit_next;
  logic       served_any_reg, served_any_next;
  logic       enter_grant_reg, enter_grant_next;
  logic       exit_grant_reg, exit_grant_next;
  logic       gate_open_reg, gate_open_next;
  logic       timeout_err_reg, timeout_err_next;

  logic enter_ok;
  logic exit_ok;
  logic in_grant;
  logic grant_is_exit;

  assign enter_ok      = Enter_Req && (count_reg < MAX_CNT);
  assign exit_ok       = Exit_Req && (count_reg != 7'd0);
  assign in_grant      = (state_reg == GRANT_ENTER) || (state_reg == GRANT_EXIT);
  assign grant_is_exit = (state_reg == GRANT_EXIT);

  always_comb begin
    state_next       = state_reg;
    count_next       = count_reg;
    timer_next       = timer_reg;
    last_exit_next   = last_exit_reg;
    served_any_next  = served_any_reg;
    timeout_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        timer_next = 8'd0;
        // On a tie, serve the lane opposite to the last one served; entry before any service.
        if (enter_ok && exit_ok) begin
          if (served_any_reg && !last_exit_reg) begin
            state_next = GRANT_EXIT;
          end else begin
            state_next = GRANT_ENTER;
          end
        end else if (enter_ok) begin
          state_next = GRANT_ENTER;
        end else if (exit_ok) begin
          state_next = GRANT_EXIT;
        end
      end

      GRANT_ENTER, GRANT_EXIT: begin
        if (Car_Passed) begin
          if (grant_is_exit) begin
            if (count_reg != 7'd0) count_next = count_reg - 7'd1;
          end else begin
            if (count_reg < MAX_CNT) count_next = count_reg + 7'd1;
          end
          last_exit_next  = grant_is_exit;
          served_any_next = 1'b1;
          timer_next      = 8'd0;
          state_next      = CLOSE;
        end else if (timer_reg == TIMER_LAST) begin
          timeout_err_next = 1'b1;
          last_exit_next   = grant_is_exit;
          served_any_next  = 1'b1;
          timer_next       = 8'd0;
          state_next       = CLOSE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end

      CLOSE: begin
        timer_next = 8'd0;
        state_next = IDLE;
      end

      default: begin
        timer_next = 8'd0;
        state_next = IDLE;
      end
    endcase

    enter_grant_next = (state_next == GRANT_ENTER);
    exit_grant_next  = (state_next == GRANT_EXIT);
    gate_open_next   = (state_next == GRANT_ENTER) || (state_next == GRANT_EXIT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= IDLE;
      count_reg       <= 7'd0;
      timer_reg       <= 8'd0;
      last_exit_reg   <= 1'b0;
      served_any_reg  <= 1'b0;
      enter_grant_reg <= 1'b0;
      exit_grant_reg  <= 1'b0;
      gate_open_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      timer_reg       <= timer_next;
      last_exit_reg   <= last_exit_next;
      served_any_reg  <= served_any_next;
      enter_grant_reg <= enter_grant_next;
      exit_grant_reg  <= exit_grant_next;
      gate_open_reg   <= gate_open_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign Enter_Grant = enter_grant_reg;
  assign Exit_Grant  = exit_grant_reg;
  assign Gate_Open   = gate_open_reg;
  assign Count       = count_reg;
  assign Full        = (count_reg == MAX_CNT);
  assign Timeout_Err = timeout_err_reg;

  logic unused_in_grant;
  assign unused_in_grant = in_grant;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomized and directed bench for parking_gate_arbiter; a lane-ownership model predicts
// every registered output each cycle, and directed sequences pin that model to literal values.
module tb_parking_gate_arbiter;

  localparam int MAXS = 100;
  localparam int TOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       er  = 1'b0;
  logic       xr  = 1'b0;
  logic       cp  = 1'b0;
  logic       eg, xg, go, full, terr;
  logic [6:0] cnt;

  int n_vec = 0;
  int n_bad = 0;

  parking_gate_arbiter #(.MAX_SPACES(MAXS), .TIMEOUT(TOUT)) dut (
    .CLK(clk), .RST(rst), .Enter_Req(er), .Exit_Req(xr), .Car_Passed(cp),
    .Enter_Grant(eg), .Exit_Grant(xg), .Gate_Open(go), .Count(cnt),
    .Full(full), .Timeout_Err(terr)
  );

  always #5 clk = ~clk;

  // Model: which lane owns the gate (0 none, 1 entry, 2 exit), how long it has owned it,
  // whether the gate is in its closing cycle, occupancy and the most recently served lane.
  int owner     = 0;
  int age       = 0;
  bit closing   = 1'b0;
  int parked    = 0;
  int last_lane = 0;
  bit abandoned = 1'b0;
  bit m_valid   = 1'b0;

  always @(posedge clk) begin
    int pick;
    abandoned = 1'b0;
    if (rst) begin
      owner = 0; age = 0; closing = 1'b0; parked = 0; last_lane = 0;
    end else if (owner != 0) begin
      if (cp || age == TOUT - 1) begin
        if (cp) parked = (owner == 1) ? parked + 1 : parked - 1;
        else abandoned = 1'b1;
        last_lane = owner;
        owner = 0;
        closing = 1'b1;
      end else begin
        age = age + 1;
      end
    end else if (closing) begin
      closing = 1'b0;
    end else begin
      pick = 0;
      if (er && parked < MAXS && xr && parked > 0) pick = (last_lane == 1) ? 2 : 1;
      else if (er && parked < MAXS) pick = 1;
      else if (xr && parked > 0) pick = 2;
      owner = pick;
      age = 0;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if (eg !== (owner == 1) || xg !== (owner == 2) || go !== (owner != 0) ||
          cnt !== 7'(parked) || full !== (parked == MAXS) || terr !== abandoned) begin
        n_bad++;
        $display("FAIL model t=%0t got eg=%b xg=%b go=%b cnt=%0d full=%b terr=%b want eg=%b xg=%b go=%b cnt=%0d full=%b terr=%b",
                 $time, eg, xg, go, cnt, full, terr, owner == 1, owner == 2, owner != 0,
                 parked, parked == MAXS, abandoned);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic wait_grant(input bit want_exit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((want_exit ? xg : eg) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_grant exit=%0d got no grant want grant within 40 cycles", want_exit);
    end
  endtask

  task automatic serve(input bit want_exit);
    if (want_exit) xr = 1'b1; else er = 1'b1;
    wait_grant(want_exit);
    er = 1'b0; xr = 1'b0; cp = 1'b1;
    @(negedge clk);
    cp = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_count", 32'(cnt), 0);
    check("reset_gate", 32'(go), 0);
    check("reset_full", 32'(full), 0);

    // Exit request with an empty lot and stray beam pulses: nothing happens.
    xr = 1'b1; cp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("empty_exit_grant", 32'(xg), 0);
      check("empty_exit_count", 32'(cnt), 0);
    end
    xr = 1'b0; cp = 1'b0;
    @(negedge clk);

    // Basic entry: grant one cycle after request, pass 3 cycles after grant.
    er = 1'b1;
    @(negedge clk);
    check("entry_grant_latency", 32'(eg), 1);
    check("entry_gate_open", 32'(go), 1);
    er = 1'b0;
    repeat (3) @(negedge clk);
    cp = 1'b1;
    @(negedge clk);
    cp = 1'b0;
    check("entry_count", 32'(cnt), 1);
    check("close_gate", 32'(go), 0);
    check("close_grant", 32'(eg), 0);
    @(negedge clk);
    check("idle_gate", 32'(go), 0);

    // Abandoned grant: 16 open cycles, then the error pulse alongside the closed gate.
    er = 1'b1;
    @(negedge clk);
    er = 1'b0;
    for (int i = 0; i < TOUT; i++) begin
      check("timeout_open", 32'(go), 1);
      check("timeout_early", 32'(terr), 0);
      @(negedge clk);
    end
    check("timeout_pulse", 32'(terr), 1);
    check("timeout_gate_closed", 32'(go), 0);
    check("timeout_count", 32'(cnt), 1);
    @(negedge clk);
    check("timeout_single", 32'(terr), 0);

    // Fill the lot, then confirm entry is refused and an exit frees a space.
    for (int i = 1; i < MAXS; i++) serve(1'b0);
    check("fill_count", 32'(cnt), MAXS);
    check("fill_full", 32'(full), 1);
    er = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("full_no_entry", 32'(eg), 0);
    end
    xr = 1'b1;
    wait_grant(1'b1);
    er = 1'b0; xr = 1'b0; cp = 1'b1;
    @(negedge clk);
    cp = 1'b0;
    check("unfill_count", 32'(cnt), MAXS - 1);
    check("unfill_full", 32'(full), 0);
    @(negedge clk);

    // Drain to 5 through the exit lane, then both lanes compete.
    repeat (MAXS - 1 - 5) serve(1'b1);
    check("drain_count", 32'(cnt), 5);
    er = 1'b1; xr = 1'b1;
    wait_grant(1'b0);
    check("tie1_no_exit", 32'(xg), 0);
    cp = 1'b1;
    @(negedge clk);
    cp = 1'b0;
    check("tie1_count", 32'(cnt), 6);
    @(negedge clk);
    wait_grant(1'b1);
    check("tie2_no_entry", 32'(eg), 0);
    cp = 1'b1;
    @(negedge clk);
    cp = 1'b0; er = 1'b0; xr = 1'b0;
    check("tie2_count", 32'(cnt), 5);
    @(negedge clk);

    // Reset in the middle of an exit grant at Count 7.
    serve(1'b0);
    serve(1'b0);
    check("pre_reset_count", 32'(cnt), 7);
    xr = 1'b1;
    wait_grant(1'b1);
    xr = 1'b0;
    @(negedge clk);
    rst = 1'b1; cp = 1'b1;
    @(negedge clk);
    rst = 1'b0; cp = 1'b0;
    check("rst_count", 32'(cnt), 0);
    check("rst_exit_grant", 32'(xg), 0);
    check("rst_gate", 32'(go), 0);
    check("rst_terr", 32'(terr), 0);
    @(negedge clk);
    check("rst_idle_gate", 32'(go), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      er  = 1'($urandom_range(0, 1));
      xr  = 1'($urandom_range(0, 1));
      cp  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0; er = 1'b0; xr = 1'b0; cp = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
